// File: rtl/demux_pkg.sv
// Shared definitions for the ingress demux and the output selector that merges the decryptor streams.
// Holds channel select codes, the serializer state encoding and the byte-count derivation.
package demux_pkg;

   localparam logic [1:0] SEL_CAESAR  = 2'd0;
   localparam logic [1:0] SEL_SCYTALE = 2'd1;
   localparam logic [1:0] SEL_ZIGZAG  = 2'd2;
   localparam logic [1:0] SEL_NONE    = 2'd3;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } demux_state_e;

   function automatic int calc_num_bytes(input int mst_dwidth, input int sys_dwidth);
      return mst_dwidth / sys_dwidth;
   endfunction

endpackage

// File: rtl/demux_serializer.sv
// Word-to-byte serializer: shift register, byte counter and ingress handshake.
// DEMUX_LSB_FIRST_EN selects LSB-first byte order; the default build emits MSB-first.
//
// state | meaning
// IDLE  | no word held, ready for a new word
// SHIFT | emitting byte[cnt_q]; ready again on the last byte for zero-bubble reload
module demux_serializer
   import demux_pkg::*;
#(
   parameter int MST_DWIDTH = 32,
   parameter int SYS_DWIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_i,
   input  logic [MST_DWIDTH-1:0] data_i,
   output logic                  ready_o,
   output logic                  accept,
   output logic [SYS_DWIDTH-1:0] byte_data,
   output logic                  byte_valid,
   output logic                  last
);

   localparam int NUM_BYTES = calc_num_bytes(MST_DWIDTH, SYS_DWIDTH);
   localparam int CNT_W     = $clog2(NUM_BYTES);

   demux_state_e          state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [MST_DWIDTH-1:0] shift_q, shift_d;

   assign last       = (state_q == SHIFT) && (cnt_q == CNT_W'(NUM_BYTES - 1));
   assign ready_o    = (state_q == IDLE) || last;
   assign accept     = valid_i && ready_o;
   assign byte_valid = (state_q == SHIFT);

`ifdef DEMUX_LSB_FIRST_EN
   assign byte_data = shift_q[SYS_DWIDTH-1:0];
`else
   assign byte_data = shift_q[MST_DWIDTH-1 -: SYS_DWIDTH];
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
         end
         SHIFT: begin
`ifdef DEMUX_LSB_FIRST_EN
            shift_d = shift_q >> SYS_DWIDTH;
`else
            shift_d = shift_q << SYS_DWIDTH;
`endif
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
      endcase
      // An acceptance on the last byte overrides the return to IDLE.
      if (accept) begin
         state_d = SHIFT;
         cnt_d   = '0;
         shift_d = data_i;
      end
   end

endmodule

// File: rtl/demux.sv
// Ingress demux: serializes accepted words and routes each byte to the captured decryptor channel.
// Byte order follows DEMUX_LSB_FIRST_EN inside the serializer; routing is identical in both builds.
module demux
   import demux_pkg::*;
#(
   parameter int MST_DWIDTH = 32,
   parameter int SYS_DWIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            select,
   input  logic [MST_DWIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [SYS_DWIDTH-1:0] data0_o,
   output logic                  valid0_o,
   output logic [SYS_DWIDTH-1:0] data1_o,
   output logic                  valid1_o,
   output logic [SYS_DWIDTH-1:0] data2_o,
   output logic                  valid2_o
);

   logic                  accept;
   logic [SYS_DWIDTH-1:0] byte_data;
   logic                  byte_valid;
   logic                  last;
   logic                  unused_last;
   logic [1:0]            sel_q;
   logic                  hit0, hit1, hit2;

   demux_serializer #(
      .MST_DWIDTH (MST_DWIDTH),
      .SYS_DWIDTH (SYS_DWIDTH)
   ) u_serializer (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_i    (valid_i),
      .data_i     (data_i),
      .ready_o    (ready_o),
      .accept     (accept),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .last       (last)
   );

   // Word-end marker is not needed for routing; the handshake already folds it into ready_o.
   assign unused_last = last;

   // SEL_NONE matches no channel, so a dropped word keeps every output at zero.
   assign hit0 = byte_valid && (sel_q == SEL_CAESAR);
   assign hit1 = byte_valid && (sel_q == SEL_SCYTALE);
   assign hit2 = byte_valid && (sel_q == SEL_ZIGZAG);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_q    <= SEL_CAESAR;
         data0_o  <= '0;
         valid0_o <= 1'b0;
         data1_o  <= '0;
         valid1_o <= 1'b0;
         data2_o  <= '0;
         valid2_o <= 1'b0;
      end else begin
         if (accept) sel_q <= select;
         valid0_o <= hit0;
         valid1_o <= hit1;
         valid2_o <= hit2;
         data0_o  <= hit0 ? byte_data : '0;
         data1_o  <= hit1 ? byte_data : '0;
         data2_o  <= hit2 ? byte_data : '0;
      end
   end

endmodule

// File: tb/tb_demux.sv
// Self-checking bench for demux: directed scenarios then random traffic against a queue-based model.
// Expected byte order follows DEMUX_LSB_FIRST_EN, matching the DUT build.
module tb_demux;

   localparam int MW = 32;
   localparam int SW = 8;
   localparam int NB = MW / SW;

   logic          clk;
   logic          rst_n;
   logic [1:0]    select;
   logic [MW-1:0] data_i;
   logic          valid_i;
   logic          ready_o;
   logic [SW-1:0] data0_o, data1_o, data2_o;
   logic          valid0_o, valid1_o, valid2_o;

   demux #(.MST_DWIDTH(MW), .SYS_DWIDTH(SW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .select   (select),
      .data_i   (data_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .data0_o  (data0_o),
      .valid0_o (valid0_o),
      .data1_o  (data1_o),
      .valid1_o (valid1_o),
      .data2_o  (data2_o),
      .valid2_o (valid2_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct packed {
      logic [1:0]    ch;
      logic [SW-1:0] b;
   } ent_t;

   // Model: every accepted word becomes NB queued (channel, byte) entries, one popped per cycle.
   ent_t          pend[$];
   logic [SW-1:0] exp_d [3];
   logic          exp_v [3];
   int            vecs = 0;
   int            errs = 0;

   function automatic logic [SW-1:0] byte_of(input logic [MW-1:0] d, input int k);
`ifdef DEMUX_LSB_FIRST_EN
      return d[SW*k +: SW];
`else
      return d[MW-1-SW*k -: SW];
`endif
   endfunction

   task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic v, input logic [MW-1:0] d, input logic [1:0] s);
      logic m_ready;
      ent_t e;
      @(negedge clk);
      rst_n   = r;
      valid_i = v;
      data_i  = d;
      select  = s;
      m_ready = (pend.size() <= 1);
      #1 chk("ready_o", {7'b0, ready_o}, {7'b0, m_ready});
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         exp_d[c] = '0;
         exp_v[c] = 1'b0;
      end
      if (!r) begin
         pend.delete();
      end else begin
         if (pend.size() > 0) begin
            e = pend.pop_front();
            if (e.ch != 2'd3) begin
               exp_d[int'(e.ch)] = e.b;
               exp_v[int'(e.ch)] = 1'b1;
            end
         end
         if (v && m_ready)
            for (int k = 0; k < NB; k++) pend.push_back('{ch: s, b: byte_of(d, k)});
      end
      #1;
      chk("data0_o",  data0_o,            exp_d[0]);
      chk("valid0_o", {7'b0, valid0_o},   {7'b0, exp_v[0]});
      chk("data1_o",  data1_o,            exp_d[1]);
      chk("valid1_o", {7'b0, valid1_o},   {7'b0, exp_v[1]});
      chk("data2_o",  data2_o,            exp_d[2]);
      chk("valid2_o", {7'b0, valid2_o},   {7'b0, exp_v[2]});
   endtask

   logic          hv;
   logic [MW-1:0] hd;
   logic          rr;

   initial begin
      rst_n   = 1'b0;
      valid_i = 1'b1;
      data_i  = 32'h55AA55AA;
      select  = 2'd0;

      // reset held with valid_i asserted
      repeat (3) step(1'b0, 1'b1, 32'h55AA55AA, 2'd0);
      step(1'b1, 1'b0, 32'h0, 2'd0);

      // single word to channel 0
      step(1'b1, 1'b1, 32'hA1B2C3D4, 2'd0);
      repeat (6) step(1'b1, 1'b0, 32'h0, 2'd0);

      // back-to-back words to channel 2
      step(1'b1, 1'b1, 32'h01020304, 2'd2);
      repeat (4) step(1'b1, 1'b1, 32'h05060708, 2'd2);
      repeat (6) step(1'b1, 1'b0, 32'h0, 2'd2);

      // select changed after acceptance
      step(1'b1, 1'b1, 32'hDEADBEEF, 2'd1);
      repeat (5) step(1'b1, 1'b0, 32'h0, 2'd0);

      // dropped word, then a normal word
      step(1'b1, 1'b1, 32'h11223344, 2'd3);
      repeat (4) step(1'b1, 1'b1, 32'h99887766, 2'd1);
      repeat (5) step(1'b1, 1'b0, 32'h0, 2'd1);

      // reset mid-word
      step(1'b1, 1'b1, 32'hCAFEF00D, 2'd0);
      repeat (2) step(1'b1, 1'b0, 32'h0, 2'd0);
      step(1'b0, 1'b0, 32'h0, 2'd0);
      repeat (4) step(1'b1, 1'b0, 32'h0, 2'd0);

      // random traffic; an unaccepted word is held stable while the model says busy
      hv = 1'b0;
      hd = '0;
      for (int i = 0; i < 500; i++) begin
         if (!(hv && pend.size() > 1)) begin
            hv = ($urandom_range(0, 2) != 0);
            hd = $urandom();
         end
         rr = ($urandom_range(0, 60) != 0);
         step(rr, hv, hd, 2'($urandom_range(0, 3)));
      end
      repeat (6) step(1'b1, 1'b0, 32'h0, 2'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
